// File: rtl/k16_mem_pkg.sv
// rtl/k16_mem_pkg.sv - shared types and default widths for the k16 memory arbiter
//
// Purpose : FSM state enum, read-owner enum and default parameter values
//           shared by k16_mem_arbiter and k16_burst_addr_gen.
// Ports   : none (package)
package k16_mem_pkg;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_VID_RUN = 4;
    // Width of the video burst length field; 0 encodes 2**LEN_W words.
    localparam int LEN_W       = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } owner_e;

endpackage

// File: rtl/k16_burst_addr_gen.sv
// rtl/k16_burst_addr_gen.sv - video burst address generator and word counter
//
// Purpose : holds the current video address and the number of words still
//           to be issued. Loaded at burst start, stepped on every video grant.
// Ports   : clk, reset (async, active low)
//           load     - latch base/len (burst accepted this cycle)
//           base,len - burst start address and word count (len 0 = 256)
//           advance  - a video slot was granted this cycle
//           addr     - address to present on the next video slot
//           last     - the next video slot is the final one of the burst
module k16_burst_addr_gen
    import k16_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    // One extra bit so a length of 0 can represent the full 256 words.
    localparam int CNT_W = LEN_W + 1;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remain_q, remain_d;

    always_comb begin
        addr_d   = addr_q;
        remain_d = remain_q;
        if (load) begin
            addr_d   = base;
            remain_d = (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
        end else if (advance && (remain_q != '0)) begin
            // Natural wrap of the adder gives modulo 2**ADDR_W addressing.
            addr_d   = addr_q + ADDR_W'(1);
            remain_d = remain_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            remain_q <= '0;
        end else begin
            addr_q   <= addr_d;
            remain_q <= remain_d;
        end
    end

    assign addr = addr_q;
    assign last = (remain_q == CNT_W'(1));

endmodule

// File: rtl/k16_mem_arbiter.sv
// rtl/k16_mem_arbiter.sv - single-port RAM arbiter between a CPU and a video burst reader
//
// Purpose : grants one RAM slot per clock to the CPU, the video reader or
//           nobody, and routes synchronous read data back to its owner.
// Build   : define K16_MEM_ARB_FAIRNESS_EN to let a waiting CPU in after
//           VID_RUN consecutive video slots; otherwise video has strict
//           priority for the whole burst.
// Ports   : clk, reset (async, active low)
//           cpu_req/cpu_we/cpu_addr/cpu_wdata  - CPU access request
//           cpu_hold                           - CPU stall (request not granted)
//           cpu_rdata/cpu_rvalid               - CPU read return
//           vid_start/vid_base/vid_len         - video burst start
//           vid_busy                           - burst in progress
//           vid_rdata/vid_valid/vid_done       - video read return, last-word pulse
//           ram_addr/ram_wdata/ram_we/ram_rdata - synchronous RAM port
module k16_mem_arbiter
    import k16_mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int VID_RUN = DEF_VID_RUN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_hold,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              vid_start,
    input  logic [ADDR_W-1:0] vid_base,
    input  logic [LEN_W-1:0]  vid_len,
    output logic              vid_busy,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_valid,
    output logic              vid_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    if (VID_RUN < 1) begin : g_vid_run_chk
        $error("VID_RUN must be at least 1");
    end

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              vid_last_q, vid_last_d;
    logic              cpu_grant, vid_grant;
    logic              burst_load;
    logic [ADDR_W-1:0] gen_addr;
    logic              gen_last;

`ifdef K16_MEM_ARB_FAIRNESS_EN
    localparam int RUN_W = $clog2(VID_RUN + 1);
    logic [RUN_W-1:0] run_q, run_d;
`endif

    assign burst_load = (state_q == ST_IDLE) && vid_start;

    k16_burst_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (burst_load),
        .base    (vid_base),
        .len     (vid_len),
        .advance (vid_grant),
        .addr    (gen_addr),
        .last    (gen_last)
    );

    // Grant decision. Nothing is granted while reset is low so cpu_hold
    // still follows cpu_req and the RAM sees no write.
    always_comb begin
        cpu_grant = 1'b0;
        vid_grant = 1'b0;
        if (reset) begin
            if (state_q == ST_IDLE) begin
                cpu_grant = cpu_req;
            end else begin
`ifdef K16_MEM_ARB_FAIRNESS_EN
                cpu_grant = cpu_req && (run_q == RUN_W'(VID_RUN));
`endif
                vid_grant = !cpu_grant;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (vid_start) state_d = ST_BURST;
            ST_BURST: if (vid_grant && gen_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Owner of the RAM data returning next cycle; CPU writes return nothing.
    always_comb begin
        owner_d = OWN_NONE;
        if (cpu_grant && !cpu_we) begin
            owner_d = OWN_CPU;
        end else if (vid_grant) begin
            owner_d = OWN_VID;
        end
        vid_last_d = vid_grant && gen_last;
    end

`ifdef K16_MEM_ARB_FAIRNESS_EN
    // Consecutive video slots since the last CPU slot. It saturates at
    // VID_RUN so a CPU that turns up late is let in on its first request.
    always_comb begin
        run_d = run_q;
        if (cpu_grant || (state_d == ST_IDLE)) begin
            run_d = '0;
        end else if (vid_grant && (run_q < RUN_W'(VID_RUN))) begin
            run_d = run_q + RUN_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_NONE;
            vid_last_q <= 1'b0;
`ifdef K16_MEM_ARB_FAIRNESS_EN
            run_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            vid_last_q <= vid_last_d;
`ifdef K16_MEM_ARB_FAIRNESS_EN
            run_q      <= run_d;
`endif
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        if (cpu_grant) begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_we    = cpu_we;
        end else if (vid_grant) begin
            ram_addr  = gen_addr;
        end
    end

    assign cpu_hold   = cpu_req && !cpu_grant;
    assign vid_busy   = (state_q == ST_BURST);

    // RAM data arrives the cycle after the address, exactly when the
    // registered owner is valid, so it is steered straight through.
    assign cpu_rvalid = (owner_q == OWN_CPU);
    assign vid_valid  = (owner_q == OWN_VID);
    assign cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
    assign vid_rdata  = vid_valid  ? ram_rdata : '0;
    assign vid_done   = vid_valid && vid_last_q;

endmodule

// File: doc/k16_mem_arbiter.md
K16_MEM_ARBITER -- requirements
Module: k16_mem_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_W, 16, address width.
REQ-002 SHALL have parameter DATA_W, 16, data width.
REQ-003 SHALL have parameter VID_RUN, 4, maximum consecutive video slots before a pending CPU access is forced in.
REQ-004 SHALL have ports (name, direction, width, meaning): clk, in, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port reset, in, 1, asynchronous active-low reset (0 = reset).
REQ-006 SHALL have CPU ports: cpu_req in 1 (access request); cpu_we in 1 (1 = write); cpu_addr in ADDR_W; cpu_wdata in DATA_W; cpu_hold out 1 (stall CPU); cpu_rdata out DATA_W; cpu_rvalid out 1 (read data valid).
REQ-007 SHALL have video ports: vid_start in 1 (1-cycle burst start pulse); vid_base in ADDR_W; vid_len in 8 (word count, 0 = 256); vid_busy out 1; vid_rdata out DATA_W; vid_valid out 1; vid_done out 1 (1-cycle pulse).
REQ-008 SHALL have RAM ports: ram_addr out ADDR_W; ram_wdata out DATA_W; ram_we out 1; ram_rdata in DATA_W (synchronous RAM, data valid the cycle after the address).

Function
REQ-009 SHALL grant exactly one RAM slot per clock, to CPU, video or nobody; ram_addr/ram_we/ram_wdata SHALL be driven combinationally from the granted requester (ram_we = 0 when no CPU write is granted).
REQ-010 SHALL implement FSM IDLE/BURST: IDLE -> BURST on vid_start (base and len latched); BURST -> IDLE on the cycle issuing the last video address.
REQ-011 SHALL ignore vid_start while in BURST; vid_busy = 1 in BURST.
REQ-012 SHALL give video priority in BURST; CPU is granted in IDLE, or in BURST when the run counter equals VID_RUN.
REQ-013 SHALL increment the run counter on each video grant, clear it on each CPU grant or on return to IDLE.
REQ-014 SHALL drive cpu_hold = cpu_req AND NOT cpu_grant (combinational).
REQ-015 SHALL generate video addresses base, base+1, ... wrapping modulo 2^ADDR_W (0xFFFF+1 = 0x0000).
REQ-016 SHALL register the read owner; one cycle after a read grant, exactly one of cpu_rvalid/vid_valid pulses with ram_rdata routed to the matching *_rdata.
REQ-017 SHALL NOT pulse cpu_rvalid for CPU writes.
REQ-018 SHALL pulse vid_done together with the last vid_valid of a burst.
REQ-019 SHALL allow vid_start on the cycle of the final vid_valid (back-to-back bursts, no lost word).

Reset
REQ-020 SHALL on reset asserted: FSM = IDLE, run counter = 0, read owner = none, cpu_rvalid = vid_valid = vid_done = vid_busy = 0, cpu_rdata = vid_rdata = 0.
REQ-021 SHALL on reset mid-burst abort the burst with no vid_done and no further vid_valid.
REQ-022 SHALL with reset low still drive cpu_hold per REQ-014 with no grant (cpu_hold = cpu_req).

Configuration
REQ-023 SHALL support macro K16_MEM_ARB_FAIRNESS_EN: defined -> REQ-012/013 run-limit applies; undefined -> run counter absent, CPU held for the whole burst (strict video priority).

Structure
REQ-024 SHALL place FSM state enum, owner enum (NONE/CPU/VID) and default widths in shared package k16_mem_pkg.
REQ-025 SHALL implement address generator/word counter as sub-module k16_burst_addr_gen; FSM, grant and return routing stay in top.

Verification
REQ-026 SHALL cover: CPU read 0x0010 in IDLE, ram[0x0010]=0x0480 -> cpu_hold 0, cpu_rvalid next cycle, cpu_rdata 0x0480.
REQ-027 SHALL cover: vid_start base 0x2000 len 8, no CPU -> 8 vid_valid on consecutive cycles, addresses 0x2000..0x2007, vid_done with eighth.
REQ-028 SHALL cover: fairness on, burst len 16 with cpu_req held -> CPU granted after every 4 video slots, burst takes 19 cycles; fairness off -> cpu_hold 1 for 16 cycles.
REQ-029 SHALL cover: base 0xFFFE len 4 -> addresses 0xFFFE,0xFFFF,0x0000,0x0001.
REQ-030 SHALL cover: CPU write 0x1234 to 0x0100 during burst -> ram_we 1 one cycle, no cpu_rvalid, readback returns 0x1234.
REQ-031 SHALL cover: reset asserted after 3rd vid_valid of len-8 burst -> outputs per REQ-020 immediately, no vid_done, new vid_start after release accepted.
